// File: rtl/mux_arbiter_pkg.sv
// mux_arbiter_pkg: state encodings, source ids and the round-robin pick shared by the arbiter and its bench
package mux_arbiter_pkg;
  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_e;
  localparam logic SRC_A = 1'b1;
  localparam logic SRC_B = 1'b0;
  // A wins when it is the only requester, or on a tie when B was granted last
  function automatic logic pick_a(input logic a_valid, input logic b_valid, input logic last);
    return a_valid & (~b_valid | (last == SRC_B));
  endfunction
endpackage

// File: rtl/mux_arbiter_mux2x1.sv
// mux_arbiter_mux2x1: two-input data mux, sel=1 picks a
module mux_arbiter_mux2x1 #(
  parameter int DATAWIDTH = 64
) (
  input  logic [DATAWIDTH-1:0] a,
  input  logic [DATAWIDTH-1:0] b,
  input  logic                 sel,
  output logic [DATAWIDTH-1:0] y
);
  always_comb y = sel ? a : b;
endmodule

// File: rtl/mux_arbiter.sv
// mux_arbiter: round-robin arbiter between two valid/ready sources feeding one registered output word
module mux_arbiter
  import mux_arbiter_pkg::*;
#(
  parameter int DATAWIDTH = 64
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic [DATAWIDTH-1:0] a,
  input  logic                 a_valid,
  output logic                 a_ready,
  input  logic [DATAWIDTH-1:0] b,
  input  logic                 b_valid,
  output logic                 b_ready,
  output logic                 sel,
  output logic [DATAWIDTH-1:0] d,
  output logic                 d_valid,
  input  logic                 d_ready
);
  state_e               state_q, state_d;
  logic                 ptr_q, ptr_d;
  logic [DATAWIDTH-1:0] d_q, d_d;
  logic [DATAWIDTH-1:0] mux_y;
  logic                 take, gnt_a, gnt_b, gnt;
  // Reset gates grants so no source sees a handshake while Rst is high
  always_comb begin
    take  = ~Rst & ((state_q == EMPTY) | d_ready);
    gnt_a = take & pick_a(a_valid, b_valid, ptr_q);
    gnt_b = take & b_valid & ~gnt_a;
    gnt   = gnt_a | gnt_b;
  end
  assign a_ready = gnt_a;
  assign b_ready = gnt_b;
  assign sel     = gnt_a;
  mux_arbiter_mux2x1 #(
    .DATAWIDTH(DATAWIDTH)
  ) mux2x1 (
    .a  (a),
    .b  (b),
    .sel(sel),
    .y  (mux_y)
  );
  always_comb begin
    state_d = gnt ? FULL : (d_ready ? EMPTY : state_q);
    ptr_d   = gnt ? (gnt_a ? SRC_A : SRC_B) : ptr_q;
    d_d     = gnt ? mux_y : d_q;
  end
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= EMPTY;
      ptr_q   <= SRC_B;
      d_q     <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      d_q     <= d_d;
    end
  end
  assign d       = d_q;
  assign d_valid = (state_q == FULL);
endmodule

// File: tb/tb_mux_arbiter.sv
// tb_mux_arbiter: directed and random checks of mux_arbiter against a transaction-level model
module tb_mux_arbiter;
  import mux_arbiter_pkg::*;
  logic       Clk = 1'b0;
  logic       Rst = 1'b1;
  logic [7:0] a = '0, b = '0, d;
  logic       a_valid = 1'b0, b_valid = 1'b0, d_ready = 1'b0;
  logic       a_ready, b_ready, sel, d_valid;
  int         checks = 0, errors = 0;
  logic       m_valid = 1'b0;
  logic [7:0] m_d = '0;
  logic       m_last = SRC_B;
  always #5 Clk = ~Clk;
  mux_arbiter #(.DATAWIDTH(8)) dut (
    .Clk(Clk), .Rst(Rst),
    .a(a), .a_valid(a_valid), .a_ready(a_ready),
    .b(b), .b_valid(b_valid), .b_ready(b_ready),
    .sel(sel), .d(d), .d_valid(d_valid), .d_ready(d_ready)
  );
  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  // One cycle: drive, check handshake outputs against the model, clock, check the output register
  task automatic step(input logic r, input logic av, input logic [7:0] ad,
                      input logic bv, input logic [7:0] bd, input logic dr);
    int winner;
    @(negedge Clk);
    Rst = r; a_valid = av; a = ad; b_valid = bv; b = bd; d_ready = dr;
    #1;
    winner = -1;
    if (!r && (!m_valid || dr)) begin
      if (av && bv) winner = (m_last == SRC_B) ? 1 : 0;
      else if (av) winner = 1;
      else if (bv) winner = 0;
    end
    chk("a_ready", {7'd0, a_ready}, {7'd0, winner == 1});
    chk("b_ready", {7'd0, b_ready}, {7'd0, winner == 0});
    chk("sel", {7'd0, sel}, {7'd0, winner == 1});
    if (r) begin
      m_valid = 1'b0; m_d = '0; m_last = SRC_B;
    end else if (winner >= 0) begin
      m_valid = 1'b1; m_d = (winner == 1) ? ad : bd; m_last = (winner == 1) ? SRC_A : SRC_B;
    end else if (dr) m_valid = 1'b0;
    @(posedge Clk);
    #1;
    chk("d_valid", {7'd0, d_valid}, {7'd0, m_valid});
    chk("d", d, m_d);
  endtask
  initial begin
    logic [7:0] tie_exp [4];
    tie_exp = '{8'h11, 8'h22, 8'h11, 8'h22};
    step(1, 1, 8'hAA, 1, 8'hBB, 1);
    step(1, 1, 8'hAA, 1, 8'hBB, 1);
    chk("rst_d", d, 8'h00);
    chk("rst_dvalid", {7'd0, d_valid}, 8'h00);
    step(0, 0, 8'h00, 1, 8'h5A, 1);
    chk("single_b_d", d, 8'h5A);
    step(1, 0, 8'h00, 0, 8'h00, 0);
    for (int i = 0; i < 4; i++) begin
      step(0, 1, 8'h11, 1, 8'h22, 1);
      chk("tie_seq", d, tie_exp[i]);
    end
    step(0, 1, 8'h33, 0, 8'h00, 1);
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 8'h55, 1, 8'h66, 0);
      chk("bp_hold", d, 8'h33);
    end
    step(0, 1, 8'h55, 1, 8'h66, 1);
    chk("bp_release", d, 8'h66);
    step(0, 0, 8'h00, 0, 8'h00, 1);
    chk("drain_dvalid", {7'd0, d_valid}, 8'h00);
    chk("drain_d", d, 8'h66);
    step(0, 1, 8'h44, 0, 8'h00, 1);
    step(1, 1, 8'h99, 1, 8'h98, 1);
    chk("midrst_d", d, 8'h00);
    step(0, 1, 8'h77, 1, 8'h88, 1);
    chk("midrst_first_a", d, 8'h77);
    for (int i = 0; i < 400; i++)
      step($urandom_range(31) == 0, 1'($urandom), 8'($urandom), 1'($urandom), 8'($urandom),
           $urandom_range(9) < 7);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mux_arbiter.md
MUX_ARBITER -- requirements
Module: mux_arbiter

Interface
REQ-001 Parameter DATAWIDTH, default 64: width of both source data buses and the output data bus.
REQ-002 Clk  input  1  single clock; all state changes on rising edge.
REQ-003 Rst  input  1  reset, synchronous, active-high.
REQ-004 a  input  DATAWIDTH  source A data.
REQ-005 a_valid  input  1  source A offers data this cycle.
REQ-006 a_ready  output  1  source A transfer accepted this cycle.
REQ-007 b  input  DATAWIDTH  source B data.
REQ-008 b_valid  input  1  source B offers data this cycle.
REQ-009 b_ready  output  1  source B transfer accepted this cycle.
REQ-010 sel  output  1  mux select: 1 = A, 0 = B.
REQ-011 d  output  DATAWIDTH  registered output data.
REQ-012 d_valid  output  1  d holds an unconsumed word.
REQ-013 d_ready  input  1  sink consumes d this cycle when d_valid=1.

Function
REQ-014 A transfer occurs on a source when valid and ready are both 1 in the same cycle; the output transfer occurs when d_valid and d_ready are both 1.
REQ-015 The block SHALL implement two states: EMPTY (d_valid=0) and FULL (d_valid=1).
REQ-016 take = (state==EMPTY) OR d_ready; sources are granted only when take=1.
REQ-017 Arbitration is round-robin via a 1-bit last-grant pointer: if only one source is valid, that source is granted; if both are valid, the source not granted most recently wins.
REQ-018 At most one of a_ready/b_ready SHALL be 1 in any cycle; neither is 1 when take=0 or when the corresponding valid is 0.
REQ-019 sel=1 when A is granted, 0 otherwise (including no grant); sel is combinational from valids, pointer and take.
REQ-020 On a grant, d SHALL load the selected source word at the next edge and d_valid SHALL be 1 from that edge: latency 1 cycle.
REQ-021 On a grant, the pointer SHALL update to the granted source at the same edge; without a grant, it holds.
REQ-022 Transitions: EMPTY->FULL on grant; FULL->FULL on grant with d_ready=1 (back-to-back, one word/cycle) or d_ready=0; FULL->EMPTY on d_ready=1 with no grant.
REQ-023 In FULL with d_ready=0, d and d_valid SHALL hold stable and both readies are 0.
REQ-024 When the block leaves FULL without a new grant, d retains its last value; only d_valid clears.
REQ-025 With both sources continuously valid and d_ready=1, grants SHALL strictly alternate A,B,A,B; neither source waits more than one grant.
REQ-026 Source readies depend combinationally on valids and d_ready; no combinational path from a/b to any control output.

Reset
REQ-027 While Rst=1 at an edge: state=EMPTY, d_valid=0, d=0, pointer=B (A wins the first tie); any word held in d is discarded.
REQ-028 a_ready and b_ready SHALL be 0 during any cycle with Rst=1, regardless of valids; sel=0.
REQ-029 Reset asserted mid-stream discards the pending word; the first grant after reset follows REQ-017 with pointer=B.

Structure
REQ-030 State encodings (EMPTY=0, FULL=1) and source IDs (SRC_A=1, SRC_B=0) SHALL live in a shared include file used by the controller and its bench.
REQ-031 The datapath SHALL instantiate one MUX2x1 (DATAWIDTH passed through, a->a, b->b, sel->sel) feeding the d register; arbitration/FSM logic stays in mux_arbiter.

Verification (DATAWIDTH=8)
REQ-032 Reset: Rst=1 with a_valid=b_valid=1 -> a_ready=b_ready=0, d_valid=0, d=0x00.
REQ-033 Single source: b_valid=1,b=0x5A, d_ready=1 -> b_ready=1, sel=0; next cycle d=0x5A, d_valid=1.
REQ-034 Tie after reset: a=0x11,b=0x22 both valid, d_ready=1 for 4 cycles -> d sequence 0x11,0x22,0x11,0x22, one word per cycle.
REQ-035 Backpressure: FULL with d=0x33, d_ready=0 for 3 cycles, both valid -> d=0x33 stable, readies 0; on d_ready=1 the round-robin winner is loaded next cycle.
REQ-036 Drain: FULL, valids 0, d_ready=1 -> next cycle d_valid=0, d unchanged.
REQ-037 Mid-stream reset: FULL with d=0x44, Rst=1 one cycle -> d_valid=0, d=0x00; then both valid -> A granted first.
